multicycle_core: RTL and testbench
==================================

Name: multicycle_core

Overview:
- Multi-cycle successor to the single-cycle MIPS processor top. It executes the same MIPS-I integer subset.
- Uses one shared, stall-capable memory port instead of separate instruction and data banks, with an explicit req/ready handshake, so wait-state memories can be attached.
- One FSM sequences FETCH/DECODE/EXEC/MEM/WB and reuses a single ALU for PC increment, branch target and data path.
- Sits at processor top level; the memory model or bus adapter sits outside it.

Parameters:
- ADDR_W, 32, memory address width; must be between 8 and 32 inclusive; PC and mem_addr are ADDR_W bits.
- RESET_PC, 0, PC value loaded on reset; must be word aligned.
- NREGS, 32, number of architected registers; legal values 16 or 32. When 16, register-field bit 4 is ignored.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory request valid; held with addr/we/wdata stable until mem_ready.
- mem_we  out  1  1 = store, 0 = load or fetch.
- mem_addr  out  ADDR_W  byte address; bits [1:0] always 0.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; sampled only in the cycle mem_ready=1 and mem_we=0.
- mem_ready  in  1  completes the current request; ignored when mem_req=0.
- halted  out  1  core stopped on an illegal opcode.
- pc_o  out  ADDR_W  architectural PC, for debug.
- Reset is synchronous and active-high on the single clock clk.

Behaviour:
- Reset (sampled at a posedge):
  - state := FETCH, PC := RESET_PC, IR := 0, halted := 0.
  - mem_req := 0 in the cycle after reset; mem_we := 0; mem_addr := RESET_PC; mem_wdata := 0.
  - Registers 1..NREGS-1 cleared to 0.
  - Reset during an outstanding request abandons it; no register or PC update happens from that request.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Stays in FETCH while mem_ready=0.
  - On mem_ready: IR := mem_rdata, PC := PC+4 (wraps modulo 2^ADDR_W), go to DECODE.
- DECODE:
  - A := R[rs], B := R[rt].
  - ALUOut := PC + (sext(imm)<<2), the branch target.
  - Illegal opcode -> HALT; otherwise go to EXEC.
- EXEC:
  - R-type funct add/sub/and/or/slt/nor: ALUOut := A op B, go to WB.
  - addi/andi/ori: addi and slti use sign-extended imm; andi and ori use zero-extended imm. Go to WB.
  - lw/sw: ALUOut := A + sext(imm), go to MEM.
  - beq/bne: if taken, PC := ALUOut (the DECODE result); go to FETCH.
  - j: PC := {PC[ADDR_W-1:28], target, 2'b00}, truncated to ADDR_W; go to FETCH.
  - Unknown R-type funct is executed as a no-op; it writes nothing.
- MEM:
  - mem_req=1, mem_addr=ALUOut[ADDR_W-1:0] with bits [1:0] forced to 0.
  - sw: mem_we=1, mem_wdata=B; on mem_ready go to FETCH.
  - lw: mem_we=0; on mem_ready, MDR := mem_rdata and go to WB.
  - Misaligned low address bits are silently cleared.
- WB:
  - Write rd (R-type) or rt (I-type) with ALUOut, or MDR for lw. Go to FETCH.
  - Writes to register 0 are discarded; reads of register 0 return 0.
- HALT: absorbing state until reset. halted=1, mem_req=0, PC frozen on the instruction after the illegal one.
- Latency with zero-wait memory (mem_ready in the same cycle as mem_req):
  - R-type/immediate ALU: 4 cycles. lw: 5. sw: 4. beq/bne/j: 3.
  - Each wait cycle adds 1.
- All arithmetic is 32-bit modulo; no overflow traps. slt is signed.

Optional Feature:
- MULTICYCLE_CORE_PERF_EN defined:
  - Adds a 32-bit cycle counter and a 32-bit retired-instruction counter, readable via ports cyc_cnt_o and ret_cnt_o.
  - Both counters reset to 0, wrap at 2^32, and freeze while halted.
  - An instruction retires on the transition out of WB, out of MEM for sw, or out of EXEC for branch/jump.
- Undefined: the counter logic is absent, and cyc_cnt_o and ret_cnt_o are tied to 0. The ports exist in both builds.

Decomposition:
- Package multicycle_pkg holds:
  - opcode and funct localparams;
  - the state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - the 4-bit ALU operation codes.
- One sub-module, mcp_regfile: NREGS x 32, two asynchronous read ports, one synchronous write port, register 0 hardwired to zero.
- The ALU stays inline.

Test Plan:
- Reset, then a zero-wait fetch of addi $1,$0,5 at RESET_PC=0 -> R1=5 after 4 cycles; PC=4; mem_req high for exactly one cycle in FETCH.
- Memory holds mem_ready low for 3 cycles during FETCH -> mem_addr and mem_req stay stable; IR is loaded only on the ready cycle; the instruction completes in 7 cycles.
- sw $1,8($0) then lw $2,8($0) -> store cycle shows mem_we=1, addr=8, wdata=5; R2=5 afterwards; lw takes 5 cycles.
- beq $1,$1,-2 at PC=0x10 -> next fetch address 0x0C. bne with equal operands -> next fetch 0x14.
- Opcode 0x3F -> halted=1 in the cycle after DECODE and mem_req stays 0. A following reset restarts the core at RESET_PC with halted=0.
- add $0,$1,$1 -> R0 still reads 0. Reset asserted mid-MEM of a sw -> no further mem_req with mem_we=1, and PC=RESET_PC.

Source files
------------

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared definitions for the multi-cycle MIPS-I core.
//   - opcode / funct encodings of the supported integer subset
//   - FSM state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT)
//   - 4-bit ALU operation codes and small decode helpers
package multicycle_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnNor = 6'h27;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluAnd = 4'd2,
        AluOr  = 4'd3,
        AluSlt = 4'd4,
        AluNor = 4'd5
    } alu_op_e;

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OpRtype, OpJ, OpBeq, OpBne, OpAddi, OpSlti,
            OpAndi, OpOri, OpLw, OpSw: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic funct_is_known(input logic [5:0] fn);
        case (fn)
            FnAdd, FnSub, FnAnd, FnOr, FnNor, FnSlt: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic alu_op_e funct_to_alu(input logic [5:0] fn);
        case (fn)
            FnSub:   return AluSub;
            FnAnd:   return AluAnd;
            FnOr:    return AluOr;
            FnNor:   return AluNor;
            FnSlt:   return AluSlt;
            default: return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/mcp_regfile.sv
// mcp_regfile: NRegs x 32 register file, register 0 hardwired to zero.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset (clears all registers)
//   raddr_a_i/rdata_a_o     asynchronous read port A
//   raddr_b_i/rdata_b_o     asynchronous read port B
//   we_i/waddr_i/wdata_i    synchronous write port
// With NRegs = 16 the top bit of every 5-bit register address is ignored.
module mcp_regfile
    import multicycle_pkg::*;
#(
    parameter int unsigned NRegs = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [4:0]      raddr_a_i,
    output logic [XLEN-1:0] rdata_a_o,
    input  logic [4:0]      raddr_b_i,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    localparam int unsigned IdxW = $clog2(NRegs);

    logic [IdxW-1:0] ra_idx, rb_idx, w_idx;
    logic [XLEN-1:0] regs_q [NRegs];
    logic [XLEN-1:0] regs_d [NRegs];

    assign ra_idx = raddr_a_i[IdxW-1:0];
    assign rb_idx = raddr_b_i[IdxW-1:0];
    assign w_idx  = waddr_i[IdxW-1:0];

    always_comb begin
        regs_d = regs_q;
        if (we_i && (w_idx != '0)) begin
            regs_d[w_idx] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a_o = (ra_idx == '0) ? '0 : regs_q[ra_idx];
    assign rdata_b_o = (rb_idx == '0) ? '0 : regs_q[rb_idx];

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle MIPS-I integer core with one shared, stall-capable memory port.
// A single FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) drives one ALU that is reused for PC+4,
// the branch target and the data path.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   mem_req/mem_we           request valid / store strobe, held stable until mem_ready
//   mem_addr/mem_wdata       word-aligned byte address / store data
//   mem_rdata/mem_ready      read data / request completion
//   halted                   core stopped on an illegal opcode
//   pc_o                     architectural PC
//   cyc_cnt_o/ret_cnt_o      cycle / retired-instruction counters
// Build option: MULTICYCLE_CORE_PERF_EN enables the counters; otherwise they read 0.
module multicycle_core
    import multicycle_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       NREGS    = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       cyc_cnt_o,
    output logic [31:0]       ret_cnt_o
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0]         aluout_q, aluout_d, mdr_q, mdr_d;

    logic [5:0]  opcode, funct;
    logic [31:0] imm_sext, imm_zext, pc_ext, jump_target;
    logic [31:0] alu_a, alu_b, alu_y;
    alu_op_e     alu_op;
    logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic [4:0]  rf_waddr;
    logic        rf_we;

    assign opcode      = ir_q[31:26];
    assign funct       = ir_q[5:0];
    assign imm_sext    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext    = {16'd0, ir_q[15:0]};
    assign pc_ext      = 32'(pc_q);
    assign jump_target = {pc_ext[31:28], ir_q[25:0], 2'b00};

    // Shared ALU
    always_comb begin
        alu_y = alu_a + alu_b;
        unique case (alu_op)
            AluAdd:  alu_y = alu_a + alu_b;
            AluSub:  alu_y = alu_a - alu_b;
            AluAnd:  alu_y = alu_a & alu_b;
            AluOr:   alu_y = alu_a | alu_b;
            AluSlt:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            AluNor:  alu_y = ~(alu_a | alu_b);
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        alu_a    = pc_ext;
        alu_b    = 32'd4;
        alu_op   = AluAdd;
        rf_we    = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = alu_y[ADDR_W-1:0];
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d      = rf_rdata_a;
                b_d      = rf_rdata_b;
                alu_b    = {imm_sext[29:0], 2'b00};
                aluout_d = alu_y;
                state_d  = op_is_legal(opcode) ? StExec : StHalt;
            end
            StExec: begin
                alu_a = a_q;
                alu_b = b_q;
                case (opcode)
                    OpRtype: begin
                        // Unknown functs still pass through WB, which suppresses the write.
                        alu_op   = funct_to_alu(funct);
                        aluout_d = alu_y;
                        state_d  = StWb;
                    end
                    OpAddi, OpSlti: begin
                        alu_op   = (opcode == OpSlti) ? AluSlt : AluAdd;
                        alu_b    = imm_sext;
                        aluout_d = alu_y;
                        state_d  = StWb;
                    end
                    OpAndi, OpOri: begin
                        alu_op   = (opcode == OpAndi) ? AluAnd : AluOr;
                        alu_b    = imm_zext;
                        aluout_d = alu_y;
                        state_d  = StWb;
                    end
                    OpLw, OpSw: begin
                        alu_b    = imm_sext;
                        aluout_d = alu_y;
                        state_d  = StMem;
                    end
                    OpBeq, OpBne: begin
                        // aluout_q still holds the branch target computed in DECODE.
                        alu_op = AluSub;
                        if ((alu_y == 32'd0) == (opcode == OpBeq)) begin
                            pc_d = aluout_q[ADDR_W-1:0];
                        end
                        state_d = StFetch;
                    end
                    OpJ: begin
                        pc_d    = jump_target[ADDR_W-1:0];
                        state_d = StFetch;
                    end
                    default: state_d = StHalt;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    if (opcode == OpSw) begin
                        state_d = StFetch;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we   = (opcode != OpRtype) || funct_is_known(funct);
                state_d = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end

    assign rf_waddr = (opcode == OpRtype) ? ir_q[15:11] : ir_q[20:16];
    assign rf_wdata = (opcode == OpLw) ? mdr_q : aluout_q;

    mcp_regfile #(
        .NRegs (NREGS)
    ) u_regfile (
        .clk_i     (clk),
        .reset_i   (reset),
        .raddr_a_i (ir_q[25:21]),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (ir_q[20:16]),
        .rdata_b_o (rf_rdata_b),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata)
    );

    // Requests are masked while reset is high so an abandoned store never completes.
    assign mem_req   = ((state_q == StFetch) || (state_q == StMem)) && !reset;
    assign mem_we    = mem_req && (state_q == StMem) && (opcode == OpSw);
    assign mem_addr  = (state_q == StMem) ? {aluout_q[ADDR_W-1:2], 2'b00}
                                          : {pc_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = mem_we ? b_q : 32'd0;
    assign halted    = (state_q == StHalt);
    assign pc_o      = pc_q;

`ifdef MULTICYCLE_CORE_PERF_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d, ret_cnt_q, ret_cnt_d;
    logic        retire;

    always_comb begin
        retire = 1'b0;
        case (state_q)
            StWb:    retire = 1'b1;
            StMem:   retire = mem_ready && (opcode == OpSw);
            StExec:  retire = (opcode == OpBeq) || (opcode == OpBne) || (opcode == OpJ);
            default: retire = 1'b0;
        endcase
        cyc_cnt_d = cyc_cnt_q;
        ret_cnt_d = ret_cnt_q;
        if (!halted) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
            ret_cnt_d = ret_cnt_q + 32'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign cyc_cnt_o = cyc_cnt_q;
    assign ret_cnt_o = ret_cnt_q;
`else
    assign cyc_cnt_o = 32'd0;
    assign ret_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed self-checking bench for multicycle_core.
// The memory model lives in the stimulus thread: each tick answers the current request
// (with a programmable number of wait cycles), performs stores and then advances one clock.
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, halted;
    logic [31:0] mem_addr, mem_wdata, pc_o, cyc_cnt_o, ret_cnt_o;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;

    logic [31:0] mem [64];
    int unsigned wait_cfg = 0;
    int unsigned age = 0;
    int unsigned req_hi = 0;
    int unsigned we_hi = 0;
    int unsigned st_cnt = 0;
    int unsigned st_save = 0;
    logic [31:0] st_addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    multicycle_core dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .pc_o      (pc_o),
        .cyc_cnt_o (cyc_cnt_o),
        .ret_cnt_o (ret_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle of memory service; called 1 time unit after a rising edge.
    task automatic tick();
        #2;
        mem_ready = mem_req && (age >= wait_cfg);
        mem_rdata = mem[mem_addr[7:2]];
        #1;
        if (mem_req) req_hi++;
        if (mem_req && mem_we) we_hi++;
        if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[7:2]] = mem_wdata;
            st_cnt++;
            st_addr = mem_addr;
            st_data = mem_wdata;
        end
        if (mem_req && !mem_ready) age++;
        else age = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[0]  = 32'h20010005;  // addi $1,$0,5
        mem[1]  = 32'h00011822;  // sub  $3,$0,$1
        mem[2]  = 32'h0061202A;  // slt  $4,$3,$1
        mem[3]  = 32'h00002827;  // nor  $5,$0,$0
        mem[4]  = 32'h1021FFFE;  // beq  $1,$1,-2
        mem[5]  = 32'h34068000;  // ori  $6,$0,0x8000
        mem[6]  = 32'h30A7F0F0;  // andi $7,$5,0xF0F0
        mem[7]  = 32'h2868FFFF;  // slti $8,$3,-1
        mem[8]  = 32'h00A14824;  // and  $9,$5,$1
        mem[9]  = 32'h00615025;  // or   $10,$3,$1
        mem[10] = 32'h00210020;  // add  $0,$1,$1
        mem[11] = 32'h08000010;  // j    0x40
        mem[16] = 32'hAC010008;  // sw   $1,8($0)
        mem[17] = 32'h8C020008;  // lw   $2,8($0)
        mem[18] = 32'hFC000000;  // illegal opcode 0x3F

        // Reset state
        @(posedge clk);
        #1;
        ticks(2);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ir", dut.ir_q, 32'd0);

        // addi, zero wait: 4 cycles, one request cycle
        reset = 1'b0;
        req_hi = 0;
        tick();
        chk("addi_ir", dut.ir_q, 32'h20010005);
        chk("addi_pc", pc_o, 32'd4);
        ticks(3);
        chk("addi_r1", dut.u_regfile.regs_q[1], 32'd5);
        chk("addi_req_cycles", req_hi, 32'd1);
        chk("addi_next_req", {31'd0, mem_req}, 32'd1);
        chk("addi_next_addr", mem_addr, 32'd4);

        // sub with a 3-cycle fetch stall: 7 cycles total
        wait_cfg = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req", {31'd0, mem_req}, 32'd1);
            chk("stall_addr", mem_addr, 32'd4);
            chk("stall_ir_held", dut.ir_q, 32'h20010005);
        end
        tick();
        chk("stall_ir_load", dut.ir_q, 32'h00011822);
        chk("stall_pc", pc_o, 32'd8);
        wait_cfg = 0;
        ticks(3);
        chk("sub_r3", dut.u_regfile.regs_q[3], 32'hFFFFFFFB);
        chk("sub_next_addr", mem_addr, 32'd8);

        // slt, nor, then taken beq
        ticks(8);
        chk("slt_r4", dut.u_regfile.regs_q[4], 32'd1);
        chk("nor_r5", dut.u_regfile.regs_q[5], 32'hFFFFFFFF);
        ticks(3);
        chk("beq_req", {31'd0, mem_req}, 32'd1);
        chk("beq_fetch_addr", mem_addr, 32'h0000000C);
        chk("beq_pc", pc_o, 32'h0000000C);

        // Second run: bne not taken, immediates, R0, jump, sw/lw, illegal opcode
        reset = 1'b1;
        mem[4] = 32'h1421FFFE;  // bne $1,$1,-2
        ticks(2);
        chk("rst2_pc", pc_o, 32'd0);
        reset = 1'b0;
        ticks(16);
        ticks(3);
        chk("bne_fetch_addr", mem_addr, 32'h00000014);
        chk("bne_pc", pc_o, 32'h00000014);
        ticks(24);
        chk("ori_r6", dut.u_regfile.regs_q[6], 32'h00008000);
        chk("andi_r7", dut.u_regfile.regs_q[7], 32'h0000F0F0);
        chk("slti_r8", dut.u_regfile.regs_q[8], 32'd1);
        chk("and_r9", dut.u_regfile.regs_q[9], 32'd5);
        chk("or_r10", dut.u_regfile.regs_q[10], 32'hFFFFFFFF);
        chk("add_r0", dut.u_regfile.regs_q[0], 32'd0);
        ticks(3);
        chk("j_pc", pc_o, 32'h00000040);

        st_cnt = 0;
        ticks(3);
        chk("sw_we", {31'd0, mem_we}, 32'd1);
        chk("sw_addr", mem_addr, 32'd8);
        chk("sw_wdata", mem_wdata, 32'd5);
        tick();
        chk("sw_store_cnt", st_cnt, 32'd1);
        chk("sw_store_addr", st_addr, 32'd8);
        chk("sw_store_data", st_data, 32'd5);
        chk("sw_next_addr", mem_addr, 32'h00000044);

        ticks(4);
        chk("lw_wb_no_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("lw_r2", dut.u_regfile.regs_q[2], 32'd5);
        chk("lw_next_addr", mem_addr, 32'h00000048);
        chk("lw_next_req", {31'd0, mem_req}, 32'd1);

        ticks(2);
        chk("ill_halted", {31'd0, halted}, 32'd1);
        chk("ill_no_req", {31'd0, mem_req}, 32'd0);
        chk("ill_pc", pc_o, 32'h0000004C);
        ticks(3);
        chk("halt_stays", {31'd0, halted}, 32'd1);
        chk("halt_no_req", {31'd0, mem_req}, 32'd0);
        chk("halt_pc_frozen", pc_o, 32'h0000004C);

        // Third run: restart from HALT, then reset in the middle of a stalled store
        mem[1] = 32'h08000010;  // j 0x40
        reset = 1'b1;
        tick();
        chk("rst3_halted", {31'd0, halted}, 32'd0);
        chk("rst3_pc", pc_o, 32'd0);
        reset = 1'b0;
        ticks(7);
        chk("j2_pc", pc_o, 32'h00000040);
        tick();
        wait_cfg = 5;
        ticks(2);
        tick();
        chk("mid_sw_req", {31'd0, mem_req}, 32'd1);
        chk("mid_sw_we", {31'd0, mem_we}, 32'd1);
        st_save = st_cnt;
        reset = 1'b1;
        we_hi = 0;
        tick();
        reset = 1'b0;
        wait_cfg = 0;
        chk("abort_pc", pc_o, 32'd0);
        ticks(8);
        chk("abort_no_we", we_hi, 32'd0);
        chk("abort_no_store", st_cnt, st_save);

`ifndef MULTICYCLE_CORE_PERF_EN
        chk("perf_cyc_tied", cyc_cnt_o, 32'd0);
        chk("perf_ret_tied", ret_cnt_o, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
